// File: rtl/apb_slave_pkg.sv
// Shared types and defaults for the APB slave: FSM state encoding, default
// parameter values and the WCOUNT address helper.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam int DEF_ADDR_W      = 2;
  localparam int DEF_DATA_W      = 2;
  localparam int DEF_WAIT_CYCLES = 1;

  // WCOUNT lives at the all-ones address of the map.
  function automatic int unsigned wcount_addr(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// 4-bit loadable down-counter that paces the ACCESS wait states.
module apb_wait_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/apb_slave.sv
// APB slave with a small RW register file, a read-only write counter (WCOUNT)
// at the top address, and a programmable number of wait states per transfer.
module apb_slave
  import apb_slave_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              pselx,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslave_error
);

  localparam int NREG = (1 << ADDR_W) - 1;
  localparam logic [ADDR_W-1:0] WC_ADDR = ADDR_W'(wcount_addr(ADDR_W));

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] wcount_q;
  logic              wait_zero;
  logic              latch_en;
  logic              wait_dec;
  logic              hit_wcount;
  logic              do_write;
  logic [DATA_W-1:0] rd_val;

  apb_wait_counter u_wait (
    .clk_i      (pclk),
    .rst_i      (preset),
    .load_i     (latch_en),
    .load_val_i (4'(WAIT_CYCLES)),
    .dec_i      (wait_dec),
    .zero_o     (wait_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pselx && !penable) state_d = SETUP;
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (wait_zero) begin
          // Completion cycle: a fresh setup phase chains straight into SETUP.
          state_d = (pselx && !penable) ? SETUP : IDLE;
        end else if (!pselx || !penable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // SETUP is only ever entered from IDLE or ACCESS, so this fires once per transfer.
  assign latch_en   = (state_d == SETUP);
  assign wait_dec   = (state_q == ACCESS) && !wait_zero;
  assign pready     = (state_q == ACCESS) && wait_zero;
  assign hit_wcount = (addr_q == WC_ADDR);
  assign do_write   = pready && wr_q && !hit_wcount;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else if (latch_en) begin
      addr_q  <= paddr;
      wr_q    <= pwrite;
      wdata_q <= pwdata;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wcount_q <= '0;
    end else if (do_write) begin
      regs_q[addr_q] <= wdata_q;
      wcount_q       <= wcount_q + DATA_W'(1);
    end
  end

  assign rd_val       = hit_wcount ? wcount_q : regs_q[addr_q];
  assign prdata       = (pready && !wr_q) ? rd_val : '0;
  assign pslave_error = pready && wr_q && hit_wcount;

endmodule

// File: tb/tb_apb_slave.sv
// Directed bench for apb_slave (ADDR_W=2, DATA_W=2, WAIT_CYCLES=1).
module tb_apb_slave;

  logic       pclk;
  logic       preset;
  logic       pselx;
  logic       penable;
  logic       pwrite;
  logic [1:0] paddr;
  logic [1:0] pwdata;
  logic [1:0] prdata;
  logic       pready;
  logic       pslave_error;

  int         vectors;
  int         miscompares;
  logic [1:0] rd_s;
  logic       err_s;

  apb_slave #(.ADDR_W(2), .DATA_W(2), .WAIT_CYCLES(1)) dut (
    .pclk         (pclk),
    .preset       (preset),
    .pselx        (pselx),
    .penable      (penable),
    .pwrite       (pwrite),
    .paddr        (paddr),
    .pwdata       (pwdata),
    .prdata       (prdata),
    .pready       (pready),
    .pslave_error (pslave_error)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one transfer up to and including its pready cycle; inputs are
  // scrambled after SETUP so only the latched values may matter.
  task automatic xfer(input logic wr, input logic [1:0] a, input logic [1:0] d);
    int lat;
    pselx = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    tick();
    chk("setup_pready", 8'(pready), 8'd0);
    chk("setup_prdata", 8'(prdata), 8'd0);
    penable = 1'b1; pwrite = ~wr; paddr = ~a; pwdata = ~d;
    lat = 1;
    tick();
    while (!pready && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", 8'(lat), 8'd2);
    rd_s  = prdata;
    err_s = pslave_error;
  endtask

  task automatic idle();
    pselx = 1'b0; penable = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [1:0] a, input logic [1:0] exp);
    xfer(1'b0, a, 2'd0);
    chk($sformatf("rd_a%0d", a), 8'(rd_s), 8'(exp));
    chk("rd_err", 8'(err_s), 8'd0);
    idle();
  endtask

  task automatic wr(input logic [1:0] a, input logic [1:0] d, input logic experr);
    xfer(1'b1, a, d);
    chk($sformatf("wr_err_a%0d", a), 8'(err_s), 8'(experr));
    idle();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    pselx = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 2'd0; pwdata = 2'd0;
    preset = 1'b1;
    tick(); tick();
    chk("rst_pready", 8'(pready), 8'd0);
    chk("rst_err", 8'(pslave_error), 8'd0);
    chk("rst_prdata", 8'(prdata), 8'd0);
    preset = 1'b0;
    tick();

    // Basic write then readback, WCOUNT = 1
    wr(2'd1, 2'b10, 1'b0);
    rd(2'd1, 2'b10);
    rd(2'd3, 2'd1);

    // Write to WCOUNT is an error and changes nothing
    wr(2'd3, 2'b11, 1'b1);
    rd(2'd3, 2'd1);
    rd(2'd0, 2'd0);
    rd(2'd1, 2'b10);
    rd(2'd2, 2'd0);

    // Back-to-back writes with pselx held high
    xfer(1'b1, 2'd0, 2'b01);
    chk("b2b1_err", 8'(err_s), 8'd0);
    xfer(1'b1, 2'd2, 2'b11);
    chk("b2b2_err", 8'(err_s), 8'd0);
    idle();
    rd(2'd0, 2'b01);
    rd(2'd2, 2'b11);
    rd(2'd3, 2'd3);

    // Abort: penable low during the wait cycle of a write to addr 0
    pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 2'd0; pwdata = 2'b10;
    tick();
    tick();
    chk("abort_wait_pready", 8'(pready), 8'd0);
    tick();
    pselx = 1'b0;
    chk("abort_idle_pready", 8'(pready), 8'd0);
    tick();
    chk("abort_after_pready", 8'(pready), 8'd0);
    rd(2'd0, 2'b01);
    rd(2'd3, 2'd3);

    // Asynchronous reset pulse during the pready cycle of a read
    xfer(1'b0, 2'd0, 2'd0);
    chk("pre_rst_prdata", 8'(rd_s), 8'b01);
    #2;
    preset = 1'b1;
    pselx = 1'b0; penable = 1'b0;
    #1;
    chk("async_rst_pready", 8'(pready), 8'd0);
    chk("async_rst_prdata", 8'(prdata), 8'd0);
    chk("async_rst_err", 8'(pslave_error), 8'd0);
    #1;
    preset = 1'b0;
    tick();
    rd(2'd0, 2'd0);
    rd(2'd1, 2'd0);
    rd(2'd2, 2'd0);
    rd(2'd3, 2'd0);

    // Five writes wrap WCOUNT modulo 4
    wr(2'd0, 2'b01, 1'b0);
    wr(2'd1, 2'b10, 1'b0);
    wr(2'd2, 2'b11, 1'b0);
    wr(2'd0, 2'b00, 1'b0);
    wr(2'd1, 2'b01, 1'b0);
    rd(2'd3, 2'b01);
    rd(2'd0, 2'b00);
    rd(2'd1, 2'b01);
    rd(2'd2, 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
